// File: rtl/mul_seq.sv
// mul_seq: sequential shift-and-add multiplier, STEP multiplier bits per cycle.
// Operands are reduced to magnitudes on accept; the product sign is applied
// once, on the final RUN cycle, so the adder only ever handles unsigned data.
module mul_seq #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    input  logic [1:0]           mode,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   res,
    output logic                 busy
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [WIDTH-1:0]     op1_mag_r;
    logic [WIDTH-1:0]     op2_mag_r;
    logic                 sign_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CW-1:0]        cnt_r;
    logic [2*WIDTH-1:0]   res_r;

    logic                 accept_s;
    logic                 last_s;
    logic                 op1_neg_s;
    logic                 op2_neg_s;
    logic [WIDTH-1:0]     op1_mag_s;
    logic [WIDTH-1:0]     op2_mag_s;
    logic [WIDTH+STEP-1:0] partial_s;
    logic [WIDTH+STEP-1:0] sum_s;
    logic [2*WIDTH-1:0]   acc_nxt_s;

    assign accept_s = (state_r == S_IDLE) && in_valid && !flush;
    assign last_s   = (state_r == S_RUN) && (cnt_r == CW'(1));

    // Decode which operands are negative for the requested mode (11 acts as 00).
    always_comb begin
        op1_neg_s = 1'b0;
        op2_neg_s = 1'b0;
        case (mode)
            2'b01: begin
                op1_neg_s = op1[WIDTH-1];
                op2_neg_s = op2[WIDTH-1];
            end
            2'b10: begin
                op1_neg_s = op1[WIDTH-1];
                op2_neg_s = 1'b0;
            end
            default: begin
                op1_neg_s = 1'b0;
                op2_neg_s = 1'b0;
            end
        endcase
    end

    // Magnitudes; the most negative value maps onto 2^(WIDTH-1), which fits unsigned.
    always_comb begin
        op1_mag_s = op1;
        op2_mag_s = op2;
        if (op1_neg_s) begin
            op1_mag_s = -op1;
        end else begin
            op1_mag_s = op1;
        end
        if (op2_neg_s) begin
            op2_mag_s = -op2;
        end else begin
            op2_mag_s = op2;
        end
    end

    // One shift-and-add step: add digit*multiplicand into the upper half, shift right.
    // The upper half never exceeds WIDTH bits, so the sum fits in WIDTH+STEP bits.
    always_comb begin
        partial_s = {{WIDTH{1'b0}}, op2_mag_r[STEP-1:0]} * {{STEP{1'b0}}, op1_mag_r};
        sum_s     = {{STEP{1'b0}}, acc_r[2*WIDTH-1:WIDTH]} + partial_s;
        acc_nxt_s = {sum_s, acc_r[WIDTH-1:STEP]};
    end

    // Next-state logic; flush wins over every handshake.
    always_comb begin
        state_nxt_s = state_r;
        if (flush) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) state_nxt_s = S_RUN;
                    else          state_nxt_s = S_IDLE;
                end
                S_RUN: begin
                    if (last_s) state_nxt_s = S_DONE;
                    else        state_nxt_s = S_RUN;
                end
                S_DONE: begin
                    if (out_ready) state_nxt_s = S_IDLE;
                    else           state_nxt_s = S_DONE;
                end
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture on accept and iteration of the accumulator during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_mag_r <= {WIDTH{1'b0}};
            op2_mag_r <= {WIDTH{1'b0}};
            sign_r    <= 1'b0;
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
        end else if (accept_s) begin
            op1_mag_r <= op1_mag_s;
            op2_mag_r <= op2_mag_s;
            sign_r    <= op1_neg_s ^ op2_neg_s;
            acc_r     <= {(2*WIDTH){1'b0}};
            cnt_r     <= CW'(N);
        end else if ((state_r == S_RUN) && !flush) begin
            acc_r     <= acc_nxt_s;
            op2_mag_r <= op2_mag_r >> STEP;
            cnt_r     <= cnt_r - CW'(1);
        end else begin
            acc_r     <= acc_r;
        end
    end

    // Result register: written only when the last step completes, so it stays stable in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= {(2*WIDTH){1'b0}};
        end else if (last_s && !flush) begin
            res_r <= sign_r ? -acc_nxt_s : acc_nxt_s;
        end else begin
            res_r <= res_r;
        end
    end

    assign in_ready  = (state_r == S_IDLE);
    assign out_valid = (state_r == S_DONE);
    assign busy      = (state_r != S_IDLE);
    assign res       = res_r;

endmodule
